core_seq: RTL and testbench
===========================

// Module: core_seq
// PURPOSE
//  Parametrised multi-cycle instruction sequencer, next generation of the core controller.
//  - Fetches 32-bit instructions over a variable-latency req/ack memory port and executes them.
//  - Drives an external register file and ALU.
//  - Adds: explicit PC register, HALT/resume, illegal-op trap, memory timeout and a retired-instruction counter.
// PARAMETERS
//  XLEN         32   data width (register, ALU and memory data)
//  ADDR_W       32   PC / memory address width; PC wraps modulo 2**ADDR_W
//  SEL_W        5    register select width; selecting all-ones as rd targets the PC
//  RESET_PC     0    PC value loaded on reset
//  MEM_TIMEOUT  256  max cycles mem_req may wait for mem_ack; 0 disables the timeout
//  CNT_W        32   width of instret
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  run        in   1       single-cycle pulse; releases HALT
//  mem_req    out  1       memory request; held until mem_ack
//  mem_we     out  1       1 = store, 0 = load or fetch
//  mem_addr   out  ADDR_W  request address
//  mem_wdata  out  XLEN    store data
//  mem_ack    in   1       completes the request in the same cycle
//  mem_rdata  in   XLEN    read data, valid with mem_ack
//  rf_sel_a   out  SEL_W   rs1 select = instr[12+:SEL_W]
//  rf_sel_b   out  SEL_W   rs2 select = instr[17+:SEL_W]
//  rf_rdata_a in   XLEN    combinational read of rs1
//  rf_rdata_b in   XLEN    combinational read of rs2
//  rf_we      out  1       register write strobe, one cycle
//  rf_sel_w   out  SEL_W   rd select = instr[7+:SEL_W]
//  rf_wdata   out  XLEN    write data
//  alu_op     out  4       instr[6:3]
//  alu_r      in   XLEN    ALU result of (alu_op, rf_rdata_a, rf_rdata_b)
//  halted     out  1       high while in HALT
//  trap       out  1       sticky until rst; set by illegal type or timeout
//  instret    out  CNT_W   count of retired instructions; wraps
// BEHAVIOUR
//  Instruction fields: type[2:0], op[6:3], rd/rs1/rs2 as above, imm = instr[31:22].
//  Instruction types: 0 NOP, 1 CALC, 2 MOV, 3 MEM, 4 HALT, 5..7 illegal.
//  Reset: state=FETCH, pc=RESET_PC. mem_req, mem_we, rf_we, halted, trap = 0; instret = 0.
//    Reset mid-transaction drops mem_req on the next edge. A late mem_ack is ignored.
//  States:
//    FETCH     mem_req=1, mem_we=0, mem_addr=pc. On mem_ack: instr <= mem_rdata, go EXEC.
//    EXEC      1 cycle.
//      NOP   pc <= pc+1.
//      CALC  rf_we=1, rf_wdata=alu_r; pc <= pc+1.
//      MOV   value = op[0] ? zero-extended imm : rf_rdata_a.
//            rd == all-ones: pc <= value, no rf write. Otherwise rf write, pc <= pc+1.
//      MEM   addr = rf_rdata_a + sign-extended imm (truncated to ADDR_W), go MEMW.
//      HALT  pc <= pc+1, go HALT.
//      5..7  go TRAP; pc is unchanged.
//    MEMW      mem_req=1, mem_we=op[0], mem_wdata=rf_rdata_b latched in EXEC.
//      On mem_ack: load writes rd with mem_rdata (rf_we the same cycle); store does no write.
//      pc <= pc+1, go FETCH.
//    HALT      halted=1, no memory traffic. run pulse -> FETCH on the next edge. run is ignored elsewhere.
//    TRAP      trap=1, mem_req=0, no rf writes. Exit only via rst.
//  Request rules:
//    - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
//    - mem_req deasserts on the edge after ack.
//    - mem_ack while mem_req=0 is ignored.
//  Latency: minimum 3 cycles for NOP/CALC/MOV/HALT (FETCH with ack in its first cycle, EXEC).
//    Minimum 4 cycles for MEM.
//  Timeout: a wait counter clears on each new request and increments per cycle with mem_req=1 and no ack.
//    When it reaches MEM_TIMEOUT-1 without ack, go TRAP and drop mem_req.
//  instret increments once per retired instruction:
//    - NOP/CALC/MOV/HALT: in EXEC.
//    - MEM: on its ack.
//    - Trapped instructions do not retire.
//  Arithmetic: pc+1 wraps to 0 at 2**ADDR_W-1. instret wraps at 2**CNT_W-1.
// STRUCTURE
//  Package core_pkg:
//    - ins_t enum (NOP, CALC, MOV, MEM, HALT)
//    - seq_state_t enum (FETCH, EXEC, MEMW, HALT, TRAP)
//    - field offset localparams
//  Sub-module core_mem_port: req/ack hold registers plus the timeout counter.
//    Outputs done and timeout pulses to the core_seq FSM.
// TESTING
//  1 Reset, fetch NOP, ack after 2 cycles -> mem_addr=0 held 3 cycles; next fetch at addr 1; instret=1.
//  2 CALC rd=3, alu_r=0x0000_00AA -> one-cycle rf_we, rf_sel_w=3, rf_wdata=0xAA; pc+1.
//  3 MOV rd=31, op[0]=1, imm=0x010 -> no rf_we; next fetch address 0x10.
//  4 Load rs1=0x100, imm=-1 (0x3FF) -> MEMW address 0xFF, mem_we=0; rdata 0x1234 written to rd.
//    Store variant -> mem_we=1, mem_wdata=rf_rdata_b, no rf_we.
//  5 HALT, then run pulse after 10 cycles -> halted high 10 cycles, no mem_req; fetch resumes at pc+1.
//  6 Fetch never acked with MEM_TIMEOUT=8 -> trap=1 after 8 req cycles, mem_req=0.
//    Illegal type 5 -> trap, instret unchanged; rst clears both.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and instruction field layout for the core sequencer.
//   ins_t       : legal instruction type encodings (5..7 are illegal)
//   seq_state_t : sequencer FSM states
//   *_LSB/_W    : bit positions of the instruction fields
package core_pkg;

    typedef enum logic [2:0] {
        INS_NOP  = 3'd0,
        INS_CALC = 3'd1,
        INS_MOV  = 3'd2,
        INS_MEM  = 3'd3,
        INS_HALT = 3'd4
    } ins_t;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEMW  = 3'd2,
        S_HALT  = 3'd3,
        S_TRAP  = 3'd4
    } seq_state_t;

    localparam int INSTR_W  = 32;
    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 3;
    localparam int OP_LSB   = 3;
    localparam int OP_W     = 4;
    localparam int RD_LSB   = 7;
    localparam int RS1_LSB  = 12;
    localparam int RS2_LSB  = 17;
    localparam int IMM_LSB  = 22;
    localparam int IMM_W    = 10;

endpackage

// File: rtl/core_mem_port.sv
// Memory request port for the core sequencer.
// Holds one req/ack transaction: a start pulse captures address, direction
// and store data, raises mem_req on the next edge and keeps everything stable
// until ack (done pulse) or until the wait counter expires (timeout pulse).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   start, start_we, start_addr,
//   start_wdata                   : launch a new request
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack            : external memory handshake
//   done                          : ack accepted this cycle
//   timeout                       : wait limit reached without ack this cycle
module core_mem_port
    import core_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [XLEN-1:0]   start_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              timeout
);

    localparam int             TW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TO_LAST = TW'(MEM_TIMEOUT - 1);
    localparam bit             TO_EN   = (MEM_TIMEOUT != 0);

    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [TW-1:0]     wait_cnt;

    // An ack with no request outstanding is simply not a done.
    assign done    = req_q & mem_ack;
    assign timeout = TO_EN & req_q & ~mem_ack & (wait_cnt == TO_LAST);

    assign mem_req   = req_q;
    assign mem_we    = req_q & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (start) begin
                req_q <= 1'b1;
            end else if (done || timeout) begin
                req_q <= 1'b0;
            end

            if (start) begin
                wait_cnt <= '0;
            end else if (req_q && !mem_ack && wait_cnt != TO_LAST) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
        end
    end

    // Request payload: only meaningful while req_q is high, so not reset.
    always_ff @(posedge clk) begin
        if (start) begin
            we_q    <= start_we;
            addr_q  <= start_addr;
            wdata_q <= start_wdata;
        end
    end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer.
// Fetches 32-bit instructions over a req/ack memory port, executes them against
// an external register file and ALU, and keeps a PC, HALT/resume, a sticky trap
// (illegal type or memory timeout) and a retired-instruction counter.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   run                            : pulse that releases HALT
//   mem_req/we/addr/wdata/ack/rdata: memory port
//   rf_sel_a/b, rf_rdata_a/b       : register file read (rs1, rs2)
//   rf_we, rf_sel_w, rf_wdata      : register file write (rd)
//   alu_op, alu_r                  : external ALU opcode and result
//   halted, trap, instret          : status
module core_seq
    import core_pkg::*;
#(
    parameter int                XLEN        = 32,
    parameter int                ADDR_W      = 32,
    parameter int                SEL_W       = 5,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 256,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [SEL_W-1:0]  rf_sel_a,
    output logic [SEL_W-1:0]  rf_sel_b,
    input  logic [XLEN-1:0]   rf_rdata_a,
    input  logic [XLEN-1:0]   rf_rdata_b,
    output logic              rf_we,
    output logic [SEL_W-1:0]  rf_sel_w,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [3:0]        alu_op,
    input  logic [XLEN-1:0]   alu_r,
    output logic              halted,
    output logic              trap,
    output logic [CNT_W-1:0]  instret
);

    // Effective address: base plus sign-extended immediate, truncated to ADDR_W.
    function automatic logic [ADDR_W-1:0] eff_addr(input logic [XLEN-1:0]  base,
                                                   input logic [IMM_W-1:0] off);
        logic signed [XLEN-1:0] off_sx;
        logic [XLEN-1:0]        sum;
        off_sx = {{(XLEN-IMM_W){off[IMM_W-1]}}, off};
        sum    = base + off_sx;
        return ADDR_W'(sum);
    endfunction

    function automatic logic [XLEN-1:0] mov_value(input logic             use_imm,
                                                  input logic [IMM_W-1:0] imm,
                                                  input logic [XLEN-1:0]  rs1_val);
        return use_imm ? {{(XLEN-IMM_W){1'b0}}, imm} : rs1_val;
    endfunction

    seq_state_t         state_q, state_n;
    logic [ADDR_W-1:0]  pc_q, pc_n, pc_inc;
    logic [CNT_W-1:0]   instret_q, instret_n;
    logic [INSTR_W-1:0] instr_q;
    logic               instr_ld;

    logic               start, start_we;
    logic [ADDR_W-1:0]  start_addr;
    logic               done, timeout;

    logic [TYPE_W-1:0]  ityp;
    logic [OP_W-1:0]    op;
    logic [SEL_W-1:0]   rd;
    logic [IMM_W-1:0]   imm;
    logic [XLEN-1:0]    mv_val;

    assign ityp   = instr_q[TYPE_LSB +: TYPE_W];
    assign op     = instr_q[OP_LSB   +: OP_W];
    assign rd     = instr_q[RD_LSB   +: SEL_W];
    assign imm    = instr_q[IMM_LSB  +: IMM_W];
    assign mv_val = mov_value(op[0], imm, rf_rdata_a);
    assign pc_inc = pc_q + ADDR_W'(1);

    assign rf_sel_a = instr_q[RS1_LSB +: SEL_W];
    assign rf_sel_b = instr_q[RS2_LSB +: SEL_W];
    assign rf_sel_w = rd;
    assign alu_op   = op;
    assign halted   = (state_q == S_HALT);
    assign trap     = (state_q == S_TRAP);
    assign instret  = instret_q;

    core_mem_port #(
        .XLEN        (XLEN),
        .ADDR_W      (ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_port (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_we    (start_we),
        .start_addr  (start_addr),
        .start_wdata (rf_rdata_b),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .done        (done),
        .timeout     (timeout)
    );

    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        instret_n  = instret_q;
        instr_ld   = 1'b0;
        start      = 1'b0;
        start_we   = 1'b0;
        start_addr = pc_q;
        rf_we      = 1'b0;
        rf_wdata   = alu_r;

        case (state_q)
            S_FETCH: begin
                // First FETCH cycle launches the request; later cycles wait on it.
                if (!mem_req) begin
                    start = 1'b1;
                end else if (done) begin
                    instr_ld = 1'b1;
                    state_n  = S_EXEC;
                end else if (timeout) begin
                    state_n = S_TRAP;
                end
            end

            S_EXEC: begin
                state_n = S_FETCH;
                case (ityp)
                    INS_NOP: begin
                        pc_n      = pc_inc;
                        instret_n = instret_q + CNT_W'(1);
                    end
                    INS_CALC: begin
                        rf_we     = 1'b1;
                        rf_wdata  = alu_r;
                        pc_n      = pc_inc;
                        instret_n = instret_q + CNT_W'(1);
                    end
                    INS_MOV: begin
                        rf_wdata  = mv_val;
                        instret_n = instret_q + CNT_W'(1);
                        if (&rd) begin
                            pc_n = ADDR_W'(mv_val);
                        end else begin
                            rf_we = 1'b1;
                            pc_n  = pc_inc;
                        end
                    end
                    INS_MEM: begin
                        // Data request launches here so MEMW starts with mem_req up.
                        start      = 1'b1;
                        start_we   = op[0];
                        start_addr = eff_addr(rf_rdata_a, imm);
                        state_n    = S_MEMW;
                    end
                    INS_HALT: begin
                        pc_n      = pc_inc;
                        instret_n = instret_q + CNT_W'(1);
                        state_n   = S_HALT;
                    end
                    default: begin
                        state_n = S_TRAP;
                    end
                endcase
            end

            S_MEMW: begin
                if (done) begin
                    if (!op[0]) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                    pc_n      = pc_inc;
                    instret_n = instret_q + CNT_W'(1);
                    state_n   = S_FETCH;
                end else if (timeout) begin
                    state_n = S_TRAP;
                end
            end

            S_HALT: begin
                if (run) begin
                    state_n = S_FETCH;
                end
            end

            S_TRAP: begin
                state_n = S_TRAP;
            end

            default: begin
                state_n = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instret_q <= '0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            instret_q <= instret_n;
        end
    end

    always_ff @(posedge clk) begin
        if (instr_ld) begin
            instr_q <= mem_rdata[INSTR_W-1:0];
        end
    end

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  rf_sel_a, rf_sel_b, rf_sel_w;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [3:0]  alu_op;
    logic [31:0] alu_r;
    logic        halted, trap;
    logic [31:0] instret;

    int unsigned checks = 0;
    int unsigned errors = 0;

    core_seq #(
        .XLEN        (32),
        .ADDR_W      (32),
        .SEL_W       (5),
        .RESET_PC    (32'h0),
        .MEM_TIMEOUT (8),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rf_sel_a   (rf_sel_a),
        .rf_sel_b   (rf_sel_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_we      (rf_we),
        .rf_sel_w   (rf_sel_w),
        .rf_wdata   (rf_wdata),
        .alu_op     (alu_op),
        .alu_r      (alu_r),
        .halted     (halted),
        .trap       (trap),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] typ, input logic [3:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [9:0] imm);
        return {imm, rs2, rs1, rd, op, typ};
    endfunction

    // Wait (bounded) for a request, then ack it with the given data in that cycle.
    task automatic fetch(input logic [31:0] ins);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_req", mem_req, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = ins;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        int n;
        int good;
        rst        = 1'b1;
        run        = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        rf_rdata_a = '0;
        rf_rdata_b = '0;
        alu_r      = '0;
        tick();
        tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_trap", trap, 1'b0);
        chk("rst_instret", instret, 32'd0);
        rst = 1'b0;

        // 1: NOP fetch acked in its third request cycle
        tick();
        chk("t1_req_c1", {mem_req, mem_addr}, {1'b1, 32'h0});
        tick();
        chk("t1_req_c2", {mem_req, mem_addr}, {1'b1, 32'h0});
        mem_ack   = 1'b1;
        mem_rdata = enc(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 10'd0);
        #1;
        chk("t1_req_c3", {mem_req, mem_addr}, {1'b1, 32'h0});
        tick();
        mem_ack = 1'b0;
        chk("t1_exec_noreq", mem_req, 1'b0);
        tick();
        chk("t1_instret", instret, 32'd1);
        tick();
        chk("t1_next_addr", {mem_req, mem_addr}, {1'b1, 32'h1});

        // 2: CALC rd=3
        alu_r = 32'h0000_00AA;
        fetch(enc(3'd1, 4'd5, 5'd3, 5'd1, 5'd2, 10'd0));
        chk("t2_rf_we", rf_we, 1'b1);
        chk("t2_sel_w", rf_sel_w, 5'd3);
        chk("t2_wdata", rf_wdata, 32'hAA);
        chk("t2_alu_op", alu_op, 4'd5);
        tick();
        chk("t2_we_one_cycle", rf_we, 1'b0);
        tick();
        chk("t2_next_addr", mem_addr, 32'h2);

        // 3: MOV to PC with zero-extended immediate
        fetch(enc(3'd2, 4'd1, 5'd31, 5'd0, 5'd0, 10'h010));
        chk("t3_no_rf_we", rf_we, 1'b0);
        tick();
        tick();
        chk("t3_jump_addr", {mem_req, mem_addr}, {1'b1, 32'h10});
        chk("t3_instret", instret, 32'd3);

        // 4a: load, base 0x100 + (-1)
        rf_rdata_a = 32'h100;
        fetch(enc(3'd3, 4'd0, 5'd5, 5'd1, 5'd2, 10'h3FF));
        chk("t4_exec_noreq", mem_req, 1'b0);
        tick();
        chk("t4_ld_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'hFF});
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234;
        #1;
        chk("t4_ld_write", {rf_we, rf_sel_w, rf_wdata}, {1'b1, 5'd5, 32'h1234});
        tick();
        mem_ack = 1'b0;
        chk("t4_ld_req_drop", mem_req, 1'b0);
        chk("t4_ld_instret", instret, 32'd4);
        tick();
        chk("t4_ld_next_addr", mem_addr, 32'h11);

        // 4b: store, base 0x100 + 4; rs2 data captured in EXEC
        rf_rdata_b = 32'hDEAD_BEEF;
        fetch(enc(3'd3, 4'd1, 5'd6, 5'd1, 5'd2, 10'h004));
        tick();
        rf_rdata_b = 32'h5555_5555;
        #1;
        chk("t4_st_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h104});
        chk("t4_st_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        #1;
        chk("t4_st_no_rf_we", rf_we, 1'b0);
        tick();
        mem_ack = 1'b0;
        chk("t4_st_instret", instret, 32'd5);
        tick();
        chk("t4_st_next_addr", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h12});

        // 5: HALT for 10 cycles, then run
        fetch(enc(3'd4, 4'd0, 5'd0, 5'd0, 5'd0, 10'd0));
        tick();
        good = (halted && !mem_req) ? 1 : 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (halted && !mem_req) good++;
        end
        chk("t5_halt_cycles", good, 10);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("t5_resumed", {halted, mem_req}, {1'b0, 1'b0});
        chk("t5_instret", instret, 32'd6);
        tick();
        chk("t5_resume_addr", {mem_req, mem_addr}, {1'b1, 32'h13});

        // 6a: fetch never acked -> trap after 8 request cycles
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            tick();
        end
        chk("t6_req_cycles", n, 8);
        chk("t6_trap", {trap, mem_req}, {1'b1, 1'b0});
        chk("t6_instret", instret, 32'd6);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("t6_trap_sticky", {trap, halted, mem_req}, {1'b1, 1'b0, 1'b0});
        rst = 1'b1;
        tick();
        chk("t6_rst_clears", {trap, instret}, {1'b0, 32'd0});
        rst = 1'b0;

        // Reset mid-request; a late ack in the relaunch cycle must be ignored
        tick();
        chk("rst_mid_req_up", {mem_req, mem_addr}, {1'b1, 32'h0});
        rst = 1'b1;
        tick();
        chk("rst_mid_req_drop", mem_req, 1'b0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = enc(3'd4, 4'd0, 5'd0, 5'd0, 5'd0, 10'd0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("late_ack_ignored", {mem_req, mem_addr, halted}, {1'b1, 32'h0, 1'b0});

        // 6b: illegal type 5 traps and does not retire
        fetch(enc(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 10'd0));
        tick();
        tick();
        chk("t6b_addr", mem_addr, 32'h1);
        fetch(enc(3'd5, 4'd0, 5'd4, 5'd0, 5'd0, 10'd0));
        chk("t6b_exec_no_rf_we", rf_we, 1'b0);
        tick();
        chk("t6b_trap", {trap, mem_req}, {1'b1, 1'b0});
        chk("t6b_instret", instret, 32'd1);
        tick();
        tick();
        chk("t6b_trap_hold", {trap, mem_req, rf_we}, {1'b1, 1'b0, 1'b0});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6b_rst_clears", {trap, instret}, {1'b0, 32'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
